// File: rtl/l1_mem_arbiter_if.sv
// Whole-line L1 <-> memory request/response channel, valid/ready on both directions.
// Server modport faces the requester (a cache); Client modport is the issuing side.
interface l1cache_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [ID_W-1:0]   req_id;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [ID_W-1:0]   resp_id;

    modport Server (
        input  req_valid, req_we, req_addr, req_data, req_id,
        output req_ready,
        output resp_valid, resp_data, resp_id,
        input  resp_ready
    );

    modport Client (
        output req_valid, req_we, req_addr, req_data, req_id,
        input  req_ready,
        input  resp_valid, resp_data, resp_id,
        output resp_ready
    );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Two-to-one round-robin L1 memory arbiter with grant locking; zero-cycle request and response paths.
// Requests stall while a downstream request is pending or MAX_OUTSTANDING are unanswered; responses stall on the head client's resp_ready.
module l1_mem_order_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end
endmodule

module l1_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    l1cache_mem_if.Server        c0,
    l1cache_mem_if.Server        c1,
    l1cache_mem_if.Client        mem,
    output logic                 err
);
    logic last_q;
    logic lock_q;
    logic lock_src_q;
    logic err_q;

    logic gnt0;
    logic gnt1;
    logic sel;
    logic full;
    logic empty;
    logic head;
    logic req_fire;
    logic resp_fire;

    // A locked grant holds the pending source even if the other client becomes valid.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_q) begin
            gnt0 = ~lock_src_q;
            gnt1 = lock_src_q;
        end else if (c0.req_valid && c1.req_valid) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
        end else begin
            gnt0 = c0.req_valid;
            gnt1 = c1.req_valid;
        end
    end

    assign sel = gnt1;

    assign mem.req_valid = ((c0.req_valid & gnt0) | (c1.req_valid & gnt1)) & ~full;
    assign mem.req_we    = sel ? c1.req_we   : c0.req_we;
    assign mem.req_addr  = sel ? c1.req_addr : c0.req_addr;
    assign mem.req_data  = sel ? c1.req_data : c0.req_data;
    assign mem.req_id    = sel ? c1.req_id   : c0.req_id;

    assign c0.req_ready = gnt0 & mem.req_ready & ~full;
    assign c1.req_ready = gnt1 & mem.req_ready & ~full;

    assign req_fire = mem.req_valid & mem.req_ready;

    assign c0.resp_valid = mem.resp_valid & ~empty & ~head;
    assign c1.resp_valid = mem.resp_valid & ~empty & head;
    assign c0.resp_data  = mem.resp_data;
    assign c1.resp_data  = mem.resp_data;
    assign c0.resp_id    = mem.resp_id;
    assign c1.resp_id    = mem.resp_id;

    // With nothing outstanding any response is stray: sink it so memory cannot wedge.
    assign mem.resp_ready = empty | (head ? c1.resp_ready : c0.resp_ready);
    assign resp_fire      = mem.resp_valid & mem.resp_ready & ~empty;

    l1_mem_order_fifo #(
        .W     (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (resp_fire),
        .din   (sel),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (req_fire) begin
                last_q <= sel;
                lock_q <= 1'b0;
            end else if (mem.req_valid) begin
                lock_q     <= 1'b1;
                lock_src_q <= sel;
            end
            if (mem.resp_valid && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized bench for l1_mem_arbiter: spec-level model of grants, outstanding order and error flag.
module tb_l1_mem_arbiter;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    always #5 clk = ~clk;

    l1cache_mem_if c0_if ();
    l1cache_mem_if c1_if ();
    l1cache_mem_if mem_if ();

    l1_mem_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk (clk),
        .rst (rst),
        .c0  (c0_if),
        .c1  (c1_if),
        .mem (mem_if),
        .err (err)
    );

    typedef struct {
        int          t;
        logic [3:0]  id;
        logic [63:0] data;
    } mrec_t;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    int pv[2];
    int prr[2];
    int prdy;
    int dmin;
    int dmax;
    bit resp_en;
    bit stray;

    bit          cv[2];
    logic [31:0] caddr[2];
    logic [63:0] cdat[2];
    logic [3:0]  cid[2];
    logic        cwe[2];
    logic [2:0]  nxt[2];
    bit          rr[2];
    bit          mrdy;

    int    oq[$];
    mrec_t mq[$];
    int    last_src;
    int    pend_src;
    bit    err_m;
    bit    m_show;
    int    dut_log[$];
    int    dut_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic knobs(input int p0, input int p1, input int prd, input int r0, input int r1,
                         input bit ren, input int dlo, input int dhi);
        pv[0] = p0; pv[1] = p1; prdy = prd; prr[0] = r0; prr[1] = r1;
        resp_en = ren; dmin = dlo; dmax = dhi;
    endtask

    task automatic model_reset();
        oq.delete();
        mq.delete();
        last_src = 1;
        pend_src = -1;
        err_m    = 1'b0;
        m_show   = 1'b0;
        stray    = 1'b0;
        cv[0]    = 1'b0;
        cv[1]    = 1'b0;
    endtask

    task automatic drive();
        for (int x = 0; x < 2; x++) begin
            if (!cv[x] && ($urandom_range(99, 0) < pv[x])) begin
                cv[x]    = 1'b1;
                caddr[x] = $urandom;
                cdat[x]  = {$urandom, $urandom};
                cwe[x]   = 1'($urandom);
                cid[x]   = {1'(x), nxt[x]};
                nxt[x]   = nxt[x] + 3'd1;
            end
            rr[x] = ($urandom_range(99, 0) < prr[x]);
        end
        c0_if.req_valid = cv[0]; c0_if.req_addr = caddr[0]; c0_if.req_data = cdat[0];
        c0_if.req_we    = cwe[0]; c0_if.req_id  = cid[0];   c0_if.resp_ready = rr[0];
        c1_if.req_valid = cv[1]; c1_if.req_addr = caddr[1]; c1_if.req_data = cdat[1];
        c1_if.req_we    = cwe[1]; c1_if.req_id  = cid[1];   c1_if.resp_ready = rr[1];
        mrdy = ($urandom_range(99, 0) < prdy);
        mem_if.req_ready = mrdy;
        if (stray) begin
            mem_if.resp_valid = 1'b1;
            mem_if.resp_id    = 4'($urandom);
            mem_if.resp_data  = {$urandom, $urandom};
        end else if (mq.size() > 0 && (m_show || (resp_en && mq[0].t <= cyc))) begin
            m_show            = 1'b1;
            mem_if.resp_valid = 1'b1;
            mem_if.resp_id    = mq[0].id;
            mem_if.resp_data  = mq[0].data;
        end else begin
            mem_if.resp_valid = 1'b0;
            mem_if.resp_id    = '0;
            mem_if.resp_data  = '0;
        end
    endtask

    task automatic check_update();
        int    g;
        int    h;
        bit    full_m;
        bit    exp_mv;
        bit    exp_mrr;
        bit    deliver;
        mrec_t r;
        if (pend_src >= 0)        g = pend_src;
        else if (cv[0] && cv[1])  g = (last_src == 0) ? 1 : 0;
        else if (cv[0])           g = 0;
        else if (cv[1])           g = 1;
        else                      g = -1;
        full_m = (oq.size() >= MAX);
        exp_mv = (g >= 0) && !full_m;

        chk("mem_req_valid", 64'(mem_if.req_valid), 64'(exp_mv));
        chk("c0_req_ready", 64'(c0_if.req_ready), 64'((g == 0) && mrdy && !full_m));
        chk("c1_req_ready", 64'(c1_if.req_ready), 64'((g == 1) && mrdy && !full_m));
        if (exp_mv) begin
            chk("req_addr", 64'(mem_if.req_addr), 64'(caddr[g]));
            chk("req_data", mem_if.req_data, cdat[g]);
            chk("req_id", 64'(mem_if.req_id), 64'(cid[g]));
            chk("req_we", 64'(mem_if.req_we), 64'(cwe[g]));
        end
        if (c0_if.req_valid && c0_if.req_ready) dut_log.push_back(0);
        if (c1_if.req_valid && c1_if.req_ready) dut_log.push_back(1);
        if (mem_if.req_valid && mem_if.req_ready) dut_acc++;

        h       = (oq.size() > 0) ? oq[0] : -1;
        exp_mrr = (h < 0) ? 1'b1 : rr[h];
        deliver = mem_if.resp_valid && (h >= 0);
        chk("mem_resp_ready", 64'(mem_if.resp_ready), 64'(exp_mrr));
        chk("c0_resp_valid", 64'(c0_if.resp_valid), 64'(deliver && h == 0));
        chk("c1_resp_valid", 64'(c1_if.resp_valid), 64'(deliver && h == 1));
        if (deliver && exp_mrr) begin
            chk("resp_id", 64'(h == 1 ? c1_if.resp_id : c0_if.resp_id), 64'(mq[0].id));
            chk("resp_data", (h == 1) ? c1_if.resp_data : c0_if.resp_data, mq[0].data);
        end
        chk("err", 64'(err), 64'(err_m));

        if (mem_if.resp_valid) begin
            if (h < 0) begin
                err_m = 1'b1;
            end else if (exp_mrr) begin
                void'(oq.pop_front());
                void'(mq.pop_front());
                m_show = 1'b0;
            end
        end
        stray = 1'b0;
        if (exp_mv && mrdy) begin
            r.t    = cyc + $urandom_range(dmax, dmin);
            r.id   = cid[g];
            r.data = {$urandom, $urandom};
            oq.push_back(g);
            mq.push_back(r);
            last_src = g;
            pend_src = -1;
            cv[g]    = 1'b0;
        end else if (exp_mv) begin
            pend_src = g;
        end
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        if (!rst) check_update();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        knobs(0, 0, 0, 0, 0, 1'b0, 1, 1);
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        knobs(0, 0, 100, 100, 100, 1'b1, 1, 1);
        n = 0;
        while ((oq.size() > 0 || cv[0] || cv[1]) && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_done", 64'(oq.size() + int'(cv[0]) + int'(cv[1])), 64'(0));
    endtask

    initial begin
        for (int x = 0; x < 2; x++) begin
            caddr[x] = '0; cdat[x] = '0; cid[x] = '0; cwe[x] = 1'b0; nxt[x] = '0; rr[x] = 1'b0;
        end
        do_reset();
        cycle();
        chk("rst_mem_resp_ready", 64'(mem_if.resp_ready), 64'(1));
        chk("rst_err", 64'(err), 64'(0));

        // Both clients saturating: grants must alternate starting at c0.
        dut_log.delete();
        knobs(100, 100, 100, 100, 100, 1'b1, 2, 2);
        run(12);
        chk("alt_count", 64'(dut_log.size() >= 4), 64'(1));
        if (dut_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("alt_grant", 64'(dut_log[i]), 64'(i % 2));
        end

        knobs(60, 60, 30, 100, 100, 1'b1, 1, 3);
        run(300);

        // No responses: exactly MAX accepts before the order FIFO blocks.
        drain();
        dut_acc = 0;
        knobs(100, 0, 100, 100, 100, 1'b0, 1, 1);
        run(10);
        chk("fill_cnt", 64'(dut_acc), 64'(MAX));
        knobs(100, 0, 100, 100, 100, 1'b1, 1, 1);
        run(20);

        knobs(70, 70, 80, 30, 30, 1'b1, 1, 4);
        run(400);
        knobs(100, 100, 100, 50, 50, 1'b1, 1, 6);
        run(400);

        // Stray response with nothing outstanding.
        drain();
        stray = 1'b1;
        cycle();
        cycle();
        chk("stray_err", 64'(err), 64'(1));
        knobs(50, 50, 70, 70, 70, 1'b1, 1, 4);
        run(60);
        chk("err_sticky", 64'(err), 64'(1));

        // Reset with requests outstanding.
        knobs(100, 100, 100, 100, 100, 1'b0, 1, 1);
        begin
            int n;
            n = 0;
            while (oq.size() < 3 && n < 20) begin
                cycle();
                n++;
            end
        end
        chk("pre_rst_outstanding", 64'(oq.size()), 64'(3));
        do_reset();
        cycle();
        chk("rst_err_clear", 64'(err), 64'(0));
        dut_log.delete();
        dut_acc = 0;
        knobs(100, 100, 100, 100, 100, 1'b0, 1, 1);
        run(8);
        chk("post_rst_count", 64'(dut_log.size() > 0), 64'(1));
        if (dut_log.size() > 0) chk("post_rst_tie", 64'(dut_log[0]), 64'(0));
        chk("post_rst_fill", 64'(dut_acc), 64'(MAX));

        knobs(50, 50, 70, 70, 70, 1'b1, 1, 5);
        run(500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
